// File: rtl/pulse_monitor.sv
// Square-wave monitor: edge strobes, phase-width capture against a nominal
// length, saturating run counter with timeout, and a wrapping edge counter.
module pulse_monitor #(
   parameter int EXPECTED = 3,
   parameter int CW       = 8
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          pulse_in,
   output logic          rise,
   output logic          fall,
   output logic [CW-1:0] high_width,
   output logic [CW-1:0] low_width,
   output logic          width_valid,
   output logic          width_err,
   output logic          timeout,
   output logic [15:0]   edge_count
);

   typedef enum logic [1:0] {SYNC, HIGH, LOW} state_t;

   localparam logic [CW-1:0] MAX   = '1;
   localparam logic [CW-1:0] EXP_W = CW'(EXPECTED);

   state_t        state;
   state_t        state_next;
   logic          prev;
   logic [CW-1:0] run_cnt;
   logic [CW-1:0] run_next;
   logic          edge_det;
   logic          cap_high;
   logic          cap_low;
   logic          mis;

   assign edge_det = pulse_in ^ prev;
   assign mis      = (run_cnt != EXP_W);

   always_comb begin
      run_next = run_cnt;
      if (edge_det)
         run_next = CW'(1);
      else if (run_cnt != MAX)
         run_next = run_cnt + CW'(1);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state <= SYNC;
      else
         state <= state_next;
   end

   // The partial phase seen from SYNC is never reported.
   always_comb begin
      state_next = state;
      cap_high   = 1'b0;
      cap_low    = 1'b0;
      if (edge_det) begin
         unique case (state)
            SYNC: state_next = pulse_in ? HIGH : LOW;
            HIGH: begin
               if (!pulse_in) begin
                  cap_high   = 1'b1;
                  state_next = LOW;
               end
            end
            LOW: begin
               if (pulse_in) begin
                  cap_low    = 1'b1;
                  state_next = HIGH;
               end
            end
            default: state_next = SYNC;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prev        <= 1'b0;
         run_cnt     <= '0;
         rise        <= 1'b0;
         fall        <= 1'b0;
         high_width  <= '0;
         low_width   <= '0;
         width_valid <= 1'b0;
         width_err   <= 1'b0;
         timeout     <= 1'b0;
         edge_count  <= '0;
      end else begin
         prev        <= pulse_in;
         run_cnt     <= run_next;
         rise        <= edge_det & pulse_in;
         fall        <= edge_det & ~pulse_in;
         width_valid <= cap_high | cap_low;
         if (cap_high)
            high_width <= run_cnt;
         if (cap_low)
            low_width <= run_cnt;
         if ((cap_high || cap_low) && mis)
            width_err <= 1'b1;
         if (!edge_det && run_next == MAX)
            timeout <= 1'b1;
         if (edge_det)
            edge_count <= edge_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_pulse_monitor.sv
// Directed bench for pulse_monitor (EXPECTED=3, CW=8) with
// hand-computed expectations for widths, strobes and flags.
module tb_pulse_monitor;

   logic        clock;
   logic        reset;
   logic        pulse_in;
   logic        rise;
   logic        fall;
   logic [7:0]  high_width;
   logic [7:0]  low_width;
   logic        width_valid;
   logic        width_err;
   logic        timeout;
   logic [15:0] edge_count;

   int n_checks = 0;
   int n_fail   = 0;
   int n_rise;
   int n_fall;
   int n_wv;
   int last_hw;
   int last_lw;
   int err_at_wv;

   pulse_monitor #(.EXPECTED(3), .CW(8)) dut (
      .clock       (clock),
      .reset       (reset),
      .pulse_in    (pulse_in),
      .rise        (rise),
      .fall        (fall),
      .high_width  (high_width),
      .low_width   (low_width),
      .width_valid (width_valid),
      .width_err   (width_err),
      .timeout     (timeout),
      .edge_count  (edge_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clr();
      n_rise    = 0;
      n_fall    = 0;
      n_wv      = 0;
      last_hw   = -1;
      last_lw   = -1;
      err_at_wv = -1;
   endtask

   task automatic phase(input logic lvl, input int len);
      pulse_in = lvl;
      for (int i = 0; i < len; i++) begin
         @(posedge clock);
         #1;
         if (rise) n_rise++;
         if (fall) n_fall++;
         if (width_valid) begin
            n_wv++;
            last_hw   = int'(high_width);
            last_lw   = int'(low_width);
            err_at_wv = int'(width_err);
         end
      end
   endtask

   task automatic do_reset();
      pulse_in = 1'b0;
      #2 reset = 1'b1;
      #2 reset = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_rise"}, int'(rise), 0);
      check({tag, "_fall"}, int'(fall), 0);
      check({tag, "_hw"}, int'(high_width), 0);
      check({tag, "_lw"}, int'(low_width), 0);
      check({tag, "_wv"}, int'(width_valid), 0);
      check({tag, "_err"}, int'(width_err), 0);
      check({tag, "_to"}, int'(timeout), 0);
      check({tag, "_ec"}, int'(edge_count), 0);
   endtask

   initial begin
      reset    = 1'b1;
      pulse_in = 1'b0;
      #3;
      check_zero("por");
      #4 reset = 1'b0;
      clr();
      phase(1'b0, 2);
      check("idle_no_edge", int'(edge_count), 0);

      // nominal square wave, 3 high / 3 low
      clr();
      phase(1'b1, 3);
      check("first_edge_no_wv", n_wv, 0);
      check("first_edge_cnt", int'(edge_count), 1);
      phase(1'b0, 3);
      for (int k = 0; k < 6; k++) begin
         phase(1'b1, 3);
         phase(1'b0, 3);
      end
      check("sq_rise", n_rise, 7);
      check("sq_fall", n_fall, 7);
      check("sq_wv", n_wv, 13);
      check("sq_hw", int'(high_width), 3);
      check("sq_lw", int'(low_width), 3);
      check("sq_err", int'(width_err), 0);
      check("sq_to", int'(timeout), 0);
      check("sq_ec", int'(edge_count), 14);

      // one stretched high phase
      clr();
      phase(1'b1, 4);
      check("st_lw", last_lw, 3);
      phase(1'b0, 3);
      check("st_hw4", last_hw, 4);
      check("st_err_at_wv", err_at_wv, 1);
      phase(1'b1, 3);
      check("st_lw_after", last_lw, 3);
      phase(1'b0, 3);
      check("st_hw_after", last_hw, 3);
      check("st_err_sticky", int'(width_err), 1);

      // async reset in the middle of a high phase
      phase(1'b1, 2);
      #2 reset = 1'b1;
      #1;
      check_zero("async");
      #1 reset = 1'b0;
      clr();
      phase(1'b1, 3);
      check("rel_no_wv", n_wv, 0);
      check("rel_ec", int'(edge_count), 1);
      check("rel_rise", n_rise, 1);
      phase(1'b0, 3);
      check("rel_hw", last_hw, 3);
      check("rel_err", int'(width_err), 0);
      check("rel_to", int'(timeout), 0);

      // long high phase saturates run counter
      clr();
      phase(1'b1, 300);
      check("sat_wv", n_wv, 1);
      check("sat_lw", last_lw, 3);
      check("sat_to", int'(timeout), 1);
      check("sat_hw_hold", int'(high_width), 3);
      phase(1'b0, 3);
      check("sat_hw", last_hw, 255);
      check("sat_err", err_at_wv, 1);
      check("sat_ec", int'(edge_count), 4);
      check("sat_to_sticky", int'(timeout), 1);

      // toggle every cycle
      do_reset();
      clr();
      for (int k = 0; k < 5; k++) begin
         phase(1'b1, 1);
         check("tg_rise", int'(rise), 1);
         check("tg_nofall", int'(fall), 0);
         phase(1'b0, 1);
         check("tg_fall", int'(fall), 1);
         check("tg_norise", int'(rise), 0);
      end
      check("tg_nrise", n_rise, 5);
      check("tg_nfall", n_fall, 5);
      check("tg_wv", n_wv, 9);
      check("tg_hw", last_hw, 1);
      check("tg_lw", last_lw, 1);
      check("tg_err", int'(width_err), 1);
      check("tg_ec", int'(edge_count), 10);

      // edge counter wrap
      do_reset();
      for (int k = 0; k < 65537; k++) begin
         pulse_in = ~pulse_in;
         @(posedge clock);
         #1;
      end
      check("wrap_ec", int'(edge_count), 1);
      check("wrap_to", int'(timeout), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pulse_monitor.md
PULSE_MONITOR -- requirements
Module: pulse_monitor

Interface
REQ-001 Parameter EXPECTED, default 3: nominal high and low phase length, in clock cycles.
REQ-002 Parameter CW, default 8: width of the run counter and width outputs.
REQ-003 Port clock, input, 1: single clock; all state SHALL update on posedge clock only.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port pulse_in, input, 1: monitored square wave, generated from the same clock by the upstream divider.
REQ-006 Port rise, output, 1: one-cycle strobe for a detected 0->1 transition.
REQ-007 Port fall, output, 1: one-cycle strobe for a detected 1->0 transition.
REQ-008 Port high_width, output, CW: length in cycles of the last completed high phase.
REQ-009 Port low_width, output, CW: length in cycles of the last completed low phase.
REQ-010 Port width_valid, output, 1: one-cycle strobe when high_width or low_width updates.
REQ-011 Port width_err, output, 1: sticky flag set when a completed phase length differs from EXPECTED.
REQ-012 Port timeout, output, 1: sticky flag set when the run counter saturates.
REQ-013 Port edge_count, output, 16: total transitions detected since reset.

Function
REQ-014 Sampling: register prev <= pulse_in at every posedge; an edge exists when pulse_in != prev at that posedge.
REQ-015 rise/fall SHALL be registered, asserting in the cycle after the posedge at which the edge is sampled, for exactly one cycle.
REQ-016 State machine: SYNC (after reset), HIGH, LOW.
REQ-017 SYNC: count nothing into widths; on the first edge go to HIGH (rising) or LOW (falling); the partial first phase SHALL NOT be reported.
REQ-018 run_cnt SHALL load 1 on every edge and increment by 1 on each cycle without an edge.
REQ-019 run_cnt SHALL saturate at 2^CW-1 with no wrap; on reaching saturation it SHALL set timeout.
REQ-020 HIGH + falling edge: high_width <= run_cnt, width_valid=1 next cycle, go to LOW.
REQ-021 LOW + rising edge: low_width <= run_cnt, width_valid=1 next cycle, go to HIGH.
REQ-022 A reported width != EXPECTED SHALL set width_err in the same cycle that width_valid asserts.
REQ-023 width_err and timeout SHALL be cleared only by reset.
REQ-024 edge_count SHALL increment on every detected edge, including the first edge in SYNC, and SHALL wrap from 0xFFFF to 0.
REQ-025 No edge SHALL be missed for phases of 1 cycle; alternating every cycle yields width 1 each phase.
REQ-026 pulse_in X/Z is out of scope; the upstream divider SHALL present a defined level from reset.

Reset
REQ-027 While reset is high, all outputs, prev, and run_cnt SHALL be 0 and the state SHALL be SYNC.
REQ-028 These values SHALL take effect immediately on reset assertion, independent of clock.
REQ-029 Reset asserted mid-phase SHALL discard the phase; after release the next edge is treated as the first edge (REQ-017).

Verification
REQ-030 pulse_in toggling every 3 cycles for 40 cycles (EXPECTED=3) -> every width_valid reports 3/3; width_err=0; timeout=0; no width_valid for the first edge.
REQ-031 One high phase stretched to 4 cycles -> high_width=4, width_err=1 at that width_valid and held until reset; subsequent widths read 3.
REQ-032 pulse_in held high for 300 cycles after an edge -> run_cnt stops at 255; timeout=1; no width_valid until the falling edge, which then reports high_width=255.
REQ-033 pulse_in toggling every cycle -> rise/fall alternate every cycle; widths=1; width_err=1 (EXPECTED=3).
REQ-034 Reset pulsed asynchronously between clock edges mid-high-phase -> outputs 0 immediately; first edge after release gives no width_valid and edge_count=1.
REQ-035 65537 edges -> edge_count=1 (wrapped).
